// File: rtl/planificador_ticks.sv
// planificador_ticks: shared tick scheduler. One base prescaler (clk_in/CLK_DIV)
// drives N_CH programmable channels, each producing a one-cycle enable strobe
// and a 50% square wave. Config writes arrive over a valid/ready port and are
// staged, then applied on the next base-tick boundary.
// Optional build macro PLANIFICADOR_CFG_IMMEDIATE_EN: apply the staged write on
// the cycle after acceptance instead of waiting for a base tick.
`timescale 1ns/1ps

module planificador_ticks_ch #(
  parameter int RATIO_W = 8
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               base_tick,
  input  logic               apply,
  input  logic               apply_en,
  input  logic [RATIO_W-1:0] apply_ratio,
  output logic               tick,
  output logic               sq
);
  logic               en;
  logic [RATIO_W-1:0] ratio, cnt, ratio_eff;

  // A ratio of zero behaves like one so the channel never stalls.
  assign ratio_eff = (ratio == '0) ? RATIO_W'(1) : ratio;

  // Per-channel divider; a config apply overrides counting for this cycle.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      en    <= 1'b0;
      ratio <= RATIO_W'(1);
      cnt   <= '0;
      tick  <= 1'b0;
      sq    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (apply) begin
        ratio <= apply_ratio;
        cnt   <= '0;
        en    <= apply_en;
        if (!apply_en) sq <= 1'b0;
      end else if (en && base_tick) begin
        if (cnt == ratio_eff - RATIO_W'(1)) begin
          cnt  <= '0;
          tick <= 1'b1;
          sq   <= ~sq;
        end else begin
          cnt <= cnt + RATIO_W'(1);
        end
      end
    end
  end
endmodule

module planificador_ticks #(
  parameter int CLK_DIV = 50000,
  parameter int N_CH    = 4,
  parameter int RATIO_W = 8,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PRE_W  = $clog2(CLK_DIV)
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [RATIO_W-1:0] cfg_ratio,
  input  logic               cfg_enable,
  output logic               base_tick,
  output logic [N_CH-1:0]    tick_out,
  output logic [N_CH-1:0]    sq_out
);
  typedef enum logic {IDLE, PENDING} state_t;

  typedef struct packed {
    logic [CH_W-1:0]    ch;
    logic [RATIO_W-1:0] ratio;
    logic               enable;
  } cfg_t;

  state_t            state, state_nxt;
  cfg_t              stg;
  logic [PRE_W-1:0]  pre_cnt;
  logic              apply_go;
  logic [N_CH-1:0]   apply_vec;

  assign base_tick = (pre_cnt == PRE_W'(CLK_DIV - 1));

  // Free-running base prescaler, wraps every CLK_DIV cycles.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)          pre_cnt <= '0;
    else if (base_tick) pre_cnt <= '0;
    else                pre_cnt <= pre_cnt + PRE_W'(1);
  end

  // Config FSM state and staging register; staging loads on handshake.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      stg   <= '0;
    end else begin
      state <= state_nxt;
      if (cfg_valid && cfg_ready)
        stg <= '{ch: cfg_ch, ratio: cfg_ratio, enable: cfg_enable};
    end
  end

  // Next-state / handshake decode; PENDING waits for the apply point.
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    apply_go  = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_nxt = PENDING;
      end
      PENDING: begin
`ifdef PLANIFICADOR_CFG_IMMEDIATE_EN
        apply_go  = 1'b1;
        state_nxt = IDLE;
`else
        if (base_tick) begin
          apply_go  = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Route the apply to the target channel; out-of-range indices hit nothing.
  always_comb begin
    apply_vec = '0;
    for (int i = 0; i < N_CH; i++)
      apply_vec[i] = apply_go && (int'(stg.ch) == i);
  end

  planificador_ticks_ch #(.RATIO_W(RATIO_W)) u_ch [N_CH-1:0] (
    .clk_in      (clk_in),
    .reset       (reset),
    .base_tick   (base_tick),
    .apply       (apply_vec),
    .apply_en    (stg.enable),
    .apply_ratio (stg.ratio),
    .tick        (tick_out),
    .sq          (sq_out)
  );
endmodule
